byang_host_drv: RTL
===================

BYANG_HOST_DRV -- requirements
Module: byang_host_drv

Interface
REQ-001 Parameter TIMEOUT, default 1023: maximum cycles spent in WAIT_TGT or POLL before abort.
REQ-002 clk  in  1  the single clock; all logic is on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 start  in  1  request; sampled only in IDLE.
REQ-005 a_in  in  256  operand, captured on an accepted start.
REQ-006 busy  out  1  high in every state except IDLE.
REQ-007 done  out  1  one-cycle pulse when a transaction ends.
REQ-008 err  out  1  high with done when the transaction timed out.
REQ-009 result  out  256  last read-back value, held until the next done.
REQ-010 bus_dout  out  8  byte to the inverter byte-in port.
REQ-011 bus_din  in  8  byte from the inverter byte-out port.
REQ-012 bus_wr  out  1  write strobe; the target acts on its rising edge.
REQ-013 bus_rd  out  1  read strobe; the target acts on its rising edge.
REQ-014 bus_ready  in  1  target is accepting input bytes.
REQ-015 bus_valid  in  1  target result is available.

Function
REQ-016 States SHALL be IDLE, WAIT_TGT, WR_HI, WR_LO, POLL, RD_SAMPLE, RD_HI and FIN.
REQ-017 IDLE with start=1 SHALL capture a_in into a 256-bit shift register, clear byte_idx and the timeout counter, and enter WAIT_TGT.
REQ-018 WAIT_TGT SHALL enter WR_HI on the first cycle with bus_ready=1 or bus_valid=1; a target in READ accepts the first write as byte 0.
REQ-019 WR_HI SHALL drive bus_wr=1 and bus_dout=shift_reg[255:248] for exactly one cycle, then enter WR_LO.
REQ-020 WR_LO SHALL handle the byte sequence as follows:
- drive bus_wr=0 and keep bus_dout stable;
- shift the register left by 8 bits and increment byte_idx;
- return to WR_HI if byte_idx was below 31, otherwise clear the timeout counter and enter POLL.
REQ-021 Bytes SHALL be sent MSB first, 32 per transaction; the write phase SHALL take exactly 64 cycles.
REQ-022 POLL SHALL enter RD_SAMPLE on the first cycle with bus_valid=1.
REQ-023 RD_SAMPLE SHALL shift bus_din into the LSB end of the capture register and increment the read count, then:
- enter FIN after the 32nd sample;
- otherwise enter RD_HI.
REQ-024 RD_HI SHALL drive bus_rd=1 for one cycle, then enter RD_SAMPLE with bus_rd=0; each sample therefore follows the target shift.
REQ-025 The read phase SHALL take exactly 32 samples and 31 rd pulses, 63 cycles in total.
REQ-026 FIN SHALL, for one cycle, load result from the capture register, pulse done=1 with err=0, and return to IDLE.
REQ-027 bus_wr and bus_rd SHALL never be high in the same cycle.
REQ-028 Each strobe SHALL be low for at least one cycle between its high cycles.
REQ-029 Outside the WR states bus_dout SHALL hold its last value.
REQ-030 The timeout counter SHALL increment each cycle in WAIT_TGT and in POLL.
REQ-031 When the timeout counter reaches TIMEOUT, the block SHALL pulse done=1 and err=1, leave result unchanged, and go to IDLE.
REQ-032 start while busy=1 SHALL be ignored, with no queuing.
REQ-033 start asserted in the same cycle as done SHALL be ignored; the block is in FIN, not IDLE.
REQ-034 A bus_valid glitch during the write phase SHALL be ignored; only POLL observes bus_valid.

Reset
REQ-035 While rst=1 the block SHALL hold IDLE, with busy, done, err, bus_wr and bus_rd at 0, bus_dout=8'h00 and result=0.
REQ-036 Reset mid-transaction SHALL drop the strobes low asynchronously and abort without a done pulse.
REQ-037 The first transaction after reset release SHALL behave exactly as a first transaction from power-up.

Verification
REQ-038 Normal transaction: a_in=256'h1 with a target model returning 256'h1 -> bus_dout sequence of 31x 8'h00 then 8'h01, done after 64+latency+63 cycles, result=256'h1, err=0.
REQ-039 Byte ordering: a_in=256'h0102...20 -> 32 writes 8'h01..8'h20 in order, and a readback of the same pattern gives result=a_in.
REQ-040 Timeout: the target never raises bus_valid -> done=1 and err=1 exactly TIMEOUT cycles after POLL entry, and result equals its previous value.
REQ-041 Back-to-back transactions: a second start while the target holds READ state (bus_ready=0, bus_valid=1) -> writes proceed immediately and the second result is correct.
REQ-042 Reset mid-write: assert rst at byte 10 -> bus_wr=0 immediately, busy=0, no done; a fresh start afterward completes normally.
REQ-043 Strobe integrity: across all scenarios, wr and rd are never simultaneously high and no strobe stays high for more than 1 cycle.

Source files
------------

// File: rtl/byang_host_drv_if.sv
// Host-side handshake and byte-bus bundle for byang_host_drv.
// slave = the driver block, master = whoever issues requests and plays the target.
interface byang_host_drv_if;
  logic         start;
  logic [255:0] a_in;
  logic         busy;
  logic         done;
  logic         err;
  logic [255:0] result;
  logic [7:0]   bus_dout;
  logic [7:0]   bus_din;
  logic         bus_wr;
  logic         bus_rd;
  logic         bus_ready;
  logic         bus_valid;

  modport slave (
    input  start, a_in, bus_din, bus_ready, bus_valid,
    output busy, done, err, result, bus_dout, bus_wr, bus_rd
  );

  modport master (
    output start, a_in, bus_din, bus_ready, bus_valid,
    input  busy, done, err, result, bus_dout, bus_wr, bus_rd
  );
endinterface

// File: rtl/byang_host_drv.sv
// Byte-serial host driver: streams a 256-bit operand MSB-first to the target,
// polls for its result and reads 32 bytes back, with a poll/wait timeout.
module byang_host_drv #(
  parameter int TIMEOUT = 1023
) (
  input logic             clk,
  input logic             rst,
  byang_host_drv_if.slave bus
);
  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_TGT  = 3'd1;
  localparam logic [2:0] S_WR_HI     = 3'd2;
  localparam logic [2:0] S_WR_LO     = 3'd3;
  localparam logic [2:0] S_POLL      = 3'd4;
  localparam logic [2:0] S_RD_SAMPLE = 3'd5;
  localparam logic [2:0] S_RD_HI     = 3'd6;
  localparam logic [2:0] S_FIN       = 3'd7;

  logic [2:0]    r_state;
  logic [255:0]  r_shift;
  logic [255:0]  r_cap;
  logic [255:0]  r_result;
  logic [4:0]    r_idx;
  logic [TW-1:0] r_tmo;
  logic [7:0]    r_dout;
  logic          r_err;
  logic          w_tmo_hit;

  assign w_tmo_hit = (r_tmo == TMO_LAST);

  // Strobes decode straight from the state register so reset drops them at once.
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_FIN);
  assign bus.err      = (r_state == S_FIN) && r_err;
  assign bus.bus_wr   = (r_state == S_WR_HI);
  assign bus.bus_rd   = (r_state == S_RD_HI);
  assign bus.bus_dout = r_dout;
  assign bus.result   = r_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_cap    <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_tmo    <= '0;
      r_dout   <= 8'h00;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_shift <= bus.a_in;
            r_idx   <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
            r_state <= S_WAIT_TGT;
          end
        end
        S_WAIT_TGT: begin
          r_tmo <= r_tmo + 1'b1;
          // A target still parked in its read state takes the first write as byte 0.
          if (bus.bus_ready || bus.bus_valid) begin
            r_dout  <= r_shift[255:248];
            r_state <= S_WR_HI;
          end else if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_WR_HI: r_state <= S_WR_LO;
        S_WR_LO: begin
          r_shift <= {r_shift[247:0], 8'h00};
          r_idx   <= r_idx + 5'd1;
          if (r_idx == 5'd31) begin
            r_tmo   <= '0;
            r_state <= S_POLL;
          end else begin
            r_dout  <= r_shift[247:240];
            r_state <= S_WR_HI;
          end
        end
        S_POLL: begin
          r_tmo <= r_tmo + 1'b1;
          if (bus.bus_valid) r_state <= S_RD_SAMPLE;
          else if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_RD_SAMPLE: begin
          // r_idx wrapped to 0 at the end of the write phase; reused as read count.
          r_cap <= {r_cap[247:0], bus.bus_din};
          r_idx <= r_idx + 5'd1;
          r_state <= (r_idx == 5'd31) ? S_FIN : S_RD_HI;
        end
        S_RD_HI: r_state <= S_RD_SAMPLE;
        S_FIN: begin
          if (!r_err) r_result <= r_cap;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
